// File: rtl/csa_bist_seq_pkg.sv
// Shared types and constants for the CSA built-in self-test sequencer.
package csa_bist_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StApply,
    StSample,
    StDone
  } state_e;

  // Three W-bit operands need two extra bits of headroom in the sum.
  localparam int unsigned ResExtraW = 2;
  localparam int unsigned LatCntW   = 4;

  function automatic int unsigned res_width(input int unsigned w);
    return w + ResExtraW;
  endfunction

endpackage

// File: rtl/csa_golden_sum.sv
// Combinational reference adder: zero-extended a + b + c.
module csa_golden_sum
  import csa_bist_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]           a_i,
  input  logic [W-1:0]           b_i,
  input  logic [W-1:0]           c_i,
  output logic [W+ResExtraW-1:0] sum_o
);

  localparam int unsigned RW = W + ResExtraW;

  always_comb begin
    sum_o = RW'(a_i) + RW'(b_i) + RW'(c_i);
  end

endmodule

// File: rtl/csa_bist_seq.sv
// Exhaustive 3-operand pattern sequencer with clear/sample pulses for the CSA select generator.
module csa_bist_seq
  import csa_bist_seq_pkg::*;
#(
  parameter int unsigned W            = 4,
  parameter int unsigned LAT          = 1,
  parameter int unsigned NUM_PATTERNS = 4096
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  output logic [W-1:0]     operand_a,
  output logic [W-1:0]     operand_b,
  output logic [W-1:0]     operand_c,
  output logic [W+1:0]     desired_output,
  output logic             sel_init,
  output logic             test,
  output logic             busy,
  output logic             done,
  output logic [3*W-1:0]   pattern_idx
);

  localparam int unsigned         IdxW     = 3 * W;
  localparam logic [IdxW-1:0]     LastIdx  = IdxW'(NUM_PATTERNS - 1);
  localparam logic [LatCntW-1:0]  WaitInit = LatCntW'(LAT - 1);

  state_e               state_q;
  logic [LatCntW-1:0]   wait_q;
  logic [IdxW-1:0]      idx_q;
  logic [W+1:0]         sum_q;
  logic                 sel_init_q, test_q, busy_q, done_q;

  logic [IdxW-1:0]      load_idx;
  logic [W+1:0]         load_sum;

  // Index of the vector about to be applied: 0 when leaving CLEAR, else the successor.
  always_comb begin
    load_idx = (state_q == StClear) ? '0 : idx_q + IdxW'(1);
  end

  csa_golden_sum #(
    .W(W)
  ) u_golden (
    .a_i  (load_idx[W-1:0]),
    .b_i  (load_idx[2*W-1:W]),
    .c_i  (load_idx[3*W-1:2*W]),
    .sum_o(load_sum)
  );

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      sel_init_q <= 1'b0;
      test_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sel_init_q <= 1'b0;
      test_q     <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StClear;
            sel_init_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        StClear: begin
          state_q <= StApply;
          wait_q  <= WaitInit;
          idx_q   <= load_idx;
          sum_q   <= load_sum;
        end
        StApply: begin
          if (wait_q == '0) begin
            state_q <= StSample;
            test_q  <= 1'b1;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        StSample: begin
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StApply;
            wait_q  <= WaitInit;
            idx_q   <= load_idx;
            sum_q   <= load_sum;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Operands are fixed slices of the registered index, so they change only with it.
  assign operand_a      = idx_q[W-1:0];
  assign operand_b      = idx_q[2*W-1:W];
  assign operand_c      = idx_q[3*W-1:2*W];
  assign desired_output = sum_q;
  assign pattern_idx    = idx_q;
  assign sel_init       = sel_init_q;
  assign test           = test_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_csa_bist_seq.sv
// Self-checking bench: three sequencer configurations against a run-timeline model.
module tb_csa_bist_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              init;
  logic [2:0]        start_v;
  logic [2:0][3:0]   oa, ob, oc;
  logic [2:0][5:0]   od;
  logic [2:0][11:0]  pi;
  logic [2:0]        si, ts, bz, dn;

  int n_chk = 0;
  int n_err = 0;

  csa_bist_seq #(.W(4), .LAT(1), .NUM_PATTERNS(4096)) u_dut0 (
    .clk(clk), .init(init), .start(start_v[0]),
    .operand_a(oa[0]), .operand_b(ob[0]), .operand_c(oc[0]), .desired_output(od[0]),
    .sel_init(si[0]), .test(ts[0]), .busy(bz[0]), .done(dn[0]), .pattern_idx(pi[0])
  );

  csa_bist_seq #(.W(4), .LAT(3), .NUM_PATTERNS(4)) u_dut1 (
    .clk(clk), .init(init), .start(start_v[1]),
    .operand_a(oa[1]), .operand_b(ob[1]), .operand_c(oc[1]), .desired_output(od[1]),
    .sel_init(si[1]), .test(ts[1]), .busy(bz[1]), .done(dn[1]), .pattern_idx(pi[1])
  );

  csa_bist_seq #(.W(4), .LAT(15), .NUM_PATTERNS(1)) u_dut2 (
    .clk(clk), .init(init), .start(start_v[2]),
    .operand_a(oa[2]), .operand_b(ob[2]), .operand_c(oc[2]), .desired_output(od[2]),
    .sel_init(si[2]), .test(ts[2]), .busy(bz[2]), .done(dn[2]), .pattern_idx(pi[2])
  );

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 15;
    endcase
  endfunction

  function automatic int np_of(input int k);
    case (k)
      0:       return 4096;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: mode 0 idle, 1 running (t = cycles since CLEAR entry), 2 done.
  int m_st[3];
  int m_t[3];
  int m_hold[3];

  always @(posedge clk or posedge init) begin
    if (init) begin
      for (int k = 0; k < 3; k++) begin
        m_st[k]   <= 0;
        m_t[k]    <= 0;
        m_hold[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_st[k] != 1) begin
          if (start_v[k]) begin
            m_st[k] <= 1;
            m_t[k]  <= 0;
          end
        end else begin
          m_t[k] <= m_t[k] + 1;
          if (m_t[k] + 1 == 1 + np_of(k) * (lat_of(k) + 1)) begin
            m_st[k]   <= 2;
            m_hold[k] <= np_of(k) - 1;
          end
        end
      end
    end
  end

  function automatic int exp_vec(input int k);
    if (m_st[k] == 1 && m_t[k] > 0) return (m_t[k] - 1) / (lat_of(k) + 1);
    return m_hold[k];
  endfunction

  function automatic int exp_test(input int k);
    if (m_st[k] == 1 && m_t[k] > 0 && ((m_t[k] - 1) % (lat_of(k) + 1)) == lat_of(k)) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!init) begin
      for (int k = 0; k < 3; k++) begin
        int v, a, b, c;
        v = exp_vec(k);
        a = v % 16;
        b = (v / 16) % 16;
        c = v / 256;
        chk($sformatf("d%0d_a", k), int'(oa[k]), a);
        chk($sformatf("d%0d_b", k), int'(ob[k]), b);
        chk($sformatf("d%0d_c", k), int'(oc[k]), c);
        chk($sformatf("d%0d_desired", k), int'(od[k]), a + b + c);
        chk($sformatf("d%0d_idx", k), int'(pi[k]), v);
        chk($sformatf("d%0d_sel_init", k), int'(si[k]), (m_st[k] == 1 && m_t[k] == 0) ? 1 : 0);
        chk($sformatf("d%0d_test", k), int'(ts[k]), exp_test(k));
        chk($sformatf("d%0d_busy", k), int'(bz[k]), (m_st[k] == 1) ? 1 : 0);
        chk($sformatf("d%0d_done", k), int'(dn[k]), (m_st[k] == 2) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  initial begin
    int  n_tp0, n_tp2, n_si;
    bit  got0, got1, got2, found;

    init    = 1'b1;
    start_v = '0;
    tick();
    tick();
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_sel_init", int'(si[0]), 0);
    chk("rst_test", int'(ts[0]), 0);
    chk("rst_idx", int'(pi[0]), 0);
    chk("rst_desired", int'(od[0]), 0);
    init = 1'b0;
    tick();

    // Exhaustive run on dut0 and single-pattern run on dut2, both started together.
    start_v = 3'b101;
    tick();
    start_v = 3'b000;
    chk("clr_sel_init", int'(si[0]), 1);
    chk("clr_busy", int'(bz[0]), 1);
    n_tp0 = 0;
    n_tp2 = 0;
    got0  = 1'b0;
    got2  = 1'b0;
    for (int c = 1; c <= 9000 && !got0; c++) begin
      tick();
      if (c == 1) begin
        chk("v0_a", int'(oa[0]), 0);
        chk("v0_b", int'(ob[0]), 0);
        chk("v0_c", int'(oc[0]), 0);
        chk("v0_desired", int'(od[0]), 0);
        chk("v0_sel_init_low", int'(si[0]), 0);
      end
      if (c == 2) chk("v0_test", int'(ts[0]), 1);
      if (ts[0]) n_tp0++;
      if (ts[2]) n_tp2++;
      if (ts[0] && pi[0] == 12'hFFF) begin
        chk("last_a", int'(oa[0]), 15);
        chk("last_b", int'(ob[0]), 15);
        chk("last_c", int'(oc[0]), 15);
        chk("last_desired", int'(od[0]), 45);
      end
      if (dn[2] && !got2) begin
        got2 = 1'b1;
        chk("d2_done_cycle", c, 17);
        chk("d2_tests", n_tp2, 1);
      end
      if (dn[0]) begin
        got0 = 1'b1;
        chk("d0_done_cycle", c, 8193);
        chk("d0_tests", n_tp0, 4096);
      end
    end
    if (!got0) chk("d0_done_timeout", 0, 1);

    // start held high on dut1: no re-clear while busy, immediate re-clear from DONE.
    start_v[1] = 1'b1;
    tick();
    chk("d1_clr_sel_init", int'(si[1]), 1);
    n_si = 0;
    got1 = 1'b0;
    for (int c = 1; c <= 100 && !got1; c++) begin
      tick();
      if (si[1]) n_si++;
      if (ts[1] && pi[1] == 2) begin
        chk("d1_idx2_a", int'(oa[1]), 2);
        chk("d1_idx2_b", int'(ob[1]), 0);
        chk("d1_idx2_desired", int'(od[1]), 2);
      end
      if (dn[1]) begin
        got1 = 1'b1;
        chk("d1_done_cycle", c, 17);
        chk("d1_no_reclear", n_si, 0);
      end
    end
    if (!got1) chk("d1_done_timeout", 0, 1);
    tick();
    chk("d1_reclear_sel", int'(si[1]), 1);
    chk("d1_reclear_done", int'(dn[1]), 0);
    start_v[1] = 1'b0;

    // Abort dut0 with init while it waits on vector 100.
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      tick();
      if (bz[0] && !ts[0] && !si[0] && pi[0] == 100) found = 1'b1;
    end
    if (!found) chk("idx100_timeout", 0, 1);
    init = 1'b1;
    #1;
    chk("abort_a", int'(oa[0]), 0);
    chk("abort_b", int'(ob[0]), 0);
    chk("abort_desired", int'(od[0]), 0);
    chk("abort_idx", int'(pi[0]), 0);
    chk("abort_busy", int'(bz[0]), 0);
    chk("abort_test", int'(ts[0]), 0);
    chk("abort_done", int'(dn[0]), 0);
    tick();
    init       = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    chk("restart_sel_init", int'(si[0]), 1);
    chk("restart_busy", int'(bz[0]), 1);
    tick();
    chk("restart_idx", int'(pi[0]), 0);
    chk("restart_desired", int'(od[0]), 0);
    chk("restart_sel_low", int'(si[0]), 0);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
